alu_seq: RTL

- Parametrised, registered successor to the 2-bit-op combinational 16-bit ALU.
- Widens the operation set to 8 ops, adds status flags and a multi-cycle shift-add multiplier.
- Uses valid/ready handshakes on both input and output.
- Sits between an operand source (register file or test sequencer) and a result sink. Accepts one operation at a time and holds its result until the sink consumes it.

---
 rtl/alu_seq_pkg.sv | 25 ++
 rtl/alu_seq_mul.sv | 60 ++++++
 rtl/alu_seq.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag-bit positions for the alu_seq block.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;
    localparam int FLG_W = 4;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier: one partial-product step per cycle, WIDTH steps per operation.
module alu_seq_mul #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] prod_next
);
    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW:0]       cnt_q, cnt_d;

    assign busy = (cnt_q != '0);
    // done flags the final step; prod_next already includes it so the caller can register it now
    assign done = busy && (cnt_q == (SHW+1)'(1));
    assign prod_next = acc_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = (SHW+1)'(WIDTH);
        end else if (busy) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 8-op ALU with status flags, valid/ready handshakes and a multi-cycle multiplier.
// Optional accumulator operand source enabled by defining ALU_SEQ_ACC_EN.
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ALU_SEQ_ACC_EN
    input  logic             acc_sel,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             c_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);
    import alu_seq_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic [FLG_W-1:0]   flags_q, flags_d;
    logic [WIDTH-1:0]   a_eff;
    logic [WIDTH-1:0]   alu_o, res_o;
    logic               alu_c, alu_v, res_c, res_v, res_load;
    logic [WIDTH:0]     sh_wide;
    logic [SHW-1:0]     sh;
    logic               mul_start, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

`ifdef ALU_SEQ_ACC_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    assign a_eff = acc_sel ? acc_q : a;
    assign acc_d = res_load ? res_o : acc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end
`else
    assign a_eff = a;
`endif

    assign sh = b[SHW-1:0];

    // Shifts use a one-bit-wider vector so the last bit shifted out lands in the extra position
    always_comb begin
        alu_o   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sh_wide = '0;
        case (op)
            OP_ADD: begin
                {alu_c, alu_o} = {1'b0, a_eff} + {1'b0, b};
                alu_v = (a_eff[WIDTH-1] == b[WIDTH-1]) && (alu_o[WIDTH-1] != a_eff[WIDTH-1]);
            end
            OP_SUB: begin
                {alu_c, alu_o} = {1'b0, a_eff} - {1'b0, b};
                alu_v = (a_eff[WIDTH-1] != b[WIDTH-1]) && (alu_o[WIDTH-1] != a_eff[WIDTH-1]);
            end
            OP_AND: alu_o = a_eff & b;
            OP_OR:  alu_o = a_eff | b;
            OP_XOR: alu_o = a_eff ^ b;
            OP_SHL: begin
                sh_wide = {1'b0, a_eff} << sh;
                alu_o   = sh_wide[WIDTH-1:0];
                alu_c   = sh_wide[WIDTH];
            end
            OP_SHR: begin
                sh_wide = {a_eff, 1'b0} >> sh;
                alu_o   = sh_wide[WIDTH:1];
                alu_c   = sh_wide[0];
            end
            default: ;
        endcase
    end

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mul_start),
        .a         (a_eff),
        .b         (b),
        .busy      (mul_busy),
        .done      (mul_done),
        .prod_next (mul_prod)
    );

    always_comb begin
        state_d   = state_q;
        o_d       = o_q;
        flags_d   = flags_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_start = 1'b0;
        res_load  = 1'b0;
        res_o     = alu_o;
        res_c     = alu_c;
        res_v     = alu_v;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        res_load = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                if (mul_busy && mul_done) begin
                    res_load = 1'b1;
                    res_o    = mul_prod[WIDTH-1:0];
                    res_c    = |mul_prod[2*WIDTH-1:WIDTH];
                    res_v    = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (res_load) begin
            o_d            = res_o;
            flags_d[FLG_C] = res_c;
            flags_d[FLG_Z] = (res_o == '0);
            flags_d[FLG_N] = res_o[WIDTH-1];
            flags_d[FLG_V] = res_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            o_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            flags_q <= flags_d;
        end
    end

    assign o     = o_q;
    assign c_out = flags_q[FLG_C];
    assign zero  = flags_q[FLG_Z];
    assign neg   = flags_q[FLG_N];
    assign ovf   = flags_q[FLG_V];

endmodule
